// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   EX-stage ALU. Decodes {alu_op, func}, executes single-cycle ops into a
//   registered result, and runs multi-cycle mult/div (shift-add multiply,
//   restoring divide, one bit per cycle) into the HI/LO pair.
//   in_ready low is the stall request while a mult/div is in flight.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      drop this cycle's output, abort mult/div, refuse input
//   in_valid   operands/op valid this cycle
//   in_ready   unit can accept (low while mult/div busy)
//   alu_op     00 add, 01 sub, 10 R-type (use func), 11 and
//   func       R-type function field
//   shamt      shift amount for sll/srl/sra
//   a, b       operand A (rs), operand B (rt/imm)
//   ctrl       registered decoded control code
//   result     registered result
//   zero       registered (result == 0)
//   out_valid  one-cycle pulse per accepted single-cycle op
//   illegal    accepted op had an unknown func
//   md_done    one-cycle pulse when HI/LO were written
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH     = 32,
  parameter bit EN_MULDIV = 1'b1,
  localparam int SHW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             illegal,
  output logic             md_done
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b1001;
  localparam logic [3:0] C_SRL  = 4'b1010;
  localparam logic [3:0] C_SRA  = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_MFHI = 4'b1101;
  localparam logic [3:0] C_MFLO = 4'b1110;
  localparam logic [3:0] C_MD   = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t r_state, w_state_next;

  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic             r_zero, r_out_valid, r_illegal, r_md_done;

  // mult/div working state, kept apart from HI/LO so an abort leaves them intact
  logic [WIDTH-1:0] r_wk_hi, r_wk_lo, r_bm;
  logic [SHW-1:0]   r_cnt;
  logic             r_md_div, r_neg_p, r_neg_r, r_b_zero;

  logic [3:0]       w_ctrl;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal, w_md_start, w_md_signed, w_md_div, w_accept;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  // ---------------- decode ----------------
  always_comb begin
    w_ctrl      = C_ADD;
    w_illegal   = 1'b0;
    w_md_start  = 1'b0;
    w_md_signed = 1'b0;
    w_md_div    = 1'b0;
    case (alu_op)
      2'b00: w_ctrl = C_ADD;
      2'b01: w_ctrl = C_SUB;
      2'b11: w_ctrl = C_AND;
      default: begin
        case (func)
          6'b100000, 6'b100001: w_ctrl = C_ADD;
          6'b100010, 6'b100011: w_ctrl = C_SUB;
          6'b100100: w_ctrl = C_AND;
          6'b100101: w_ctrl = C_OR;
          6'b100110: w_ctrl = C_XOR;
          6'b100111: w_ctrl = C_NOR;
          6'b101010: w_ctrl = C_SLT;
          6'b101011: w_ctrl = C_SLTU;
          6'b000000: w_ctrl = C_SLL;
          6'b000010: w_ctrl = C_SRL;
          6'b000011: w_ctrl = C_SRA;
          6'b010000: begin
            if (EN_MULDIV) w_ctrl = C_MFHI;
            else           w_illegal = 1'b1;
          end
          6'b010010: begin
            if (EN_MULDIV) w_ctrl = C_MFLO;
            else           w_illegal = 1'b1;
          end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            if (EN_MULDIV) begin
              w_ctrl      = C_MD;
              w_md_start  = 1'b1;
              w_md_signed = ~func[0];   // mult/div signed, *u unsigned
              w_md_div    = func[1];
            end else begin
              w_illegal = 1'b1;
            end
          end
          default: w_illegal = 1'b1;   // falls back to add
        endcase
      end
    endcase
  end

  always_comb begin
    w_result = a + b;
    case (w_ctrl)
      C_AND:  w_result = a & b;
      C_OR:   w_result = a | b;
      C_XOR:  w_result = a ^ b;
      C_NOR:  w_result = ~(a | b);
      C_SUB:  w_result = a - b;
      C_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLTU: w_result = {{(WIDTH-1){1'b0}}, (a < b)};
      C_SLL:  w_result = b << shamt;
      C_SRL:  w_result = b >> shamt;
      C_SRA:  w_result = $signed(b) >>> shamt;
      C_MFHI: w_result = r_hi;
      C_MFLO: w_result = r_lo;
      default: w_result = a + b;
    endcase
  end

  assign in_ready = EN_MULDIV ? (r_state == S_IDLE) : 1'b1;
  assign w_accept = in_valid & in_ready & ~flush;

  assign w_a_mag = (w_md_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (w_md_signed && b[WIDTH-1]) ? -b : b;

  // ---------------- one iteration of each algorithm ----------------
  // Multiply: {wk_hi, wk_lo} holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  assign w_mul_sum = {1'b0, r_wk_hi} + (r_wk_lo[0] ? {1'b0, r_bm} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_wk_lo[WIDTH-1:1]};

  // Divide: wk_hi is the partial remainder, wk_lo shifts dividend out / quotient in.
  logic [WIDTH:0]   w_div_num;
  logic [WIDTH-1:0] w_div_sub, w_div_rem, w_div_quo;
  logic             w_div_ge;
  assign w_div_num = {r_wk_hi, r_wk_lo[WIDTH-1]};
  assign w_div_ge  = (w_div_num >= {1'b0, r_bm});
  // When the trial subtraction succeeds the difference is below the divisor,
  // so it always fits in WIDTH bits.
  assign w_div_sub = w_div_num[WIDTH-1:0] - r_bm;
  assign w_div_rem = w_div_ge ? w_div_sub : w_div_num[WIDTH-1:0];
  assign w_div_quo = {r_wk_lo[WIDTH-2:0], w_div_ge};

  // FIX performs the final iteration together with the sign correction.
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
  assign w_prod     = {w_mul_hi, w_mul_lo};
  assign w_prod_fix = r_neg_p ? -w_prod : w_prod;

  always_comb begin
    if (r_md_div) begin
      w_fix_lo = r_b_zero ? '1 : (r_neg_p ? -w_div_quo : w_div_quo);
      w_fix_hi = r_neg_r ? -w_div_rem : w_div_rem;   // remainder follows sign(a)
    end else begin
      w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_md_start) w_state_next = w_md_div ? S_DIV : S_MUL;
      // The counter reaches WIDTH-1 on the edge that leaves for FIX; FIX
      // itself handles the last bit, giving WIDTH iterations in total.
      S_MUL, S_DIV: if (r_cnt == SHW'(WIDTH-2)) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl      <= C_ADD;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_md_done   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_wk_hi     <= '0;
      r_wk_lo     <= '0;
      r_bm        <= '0;
      r_cnt       <= '0;
      r_md_div    <= 1'b0;
      r_neg_p     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_b_zero    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_md_done   <= 1'b0;
      if (!flush) begin
        if (w_accept) begin
          r_ctrl <= w_ctrl;
          if (w_md_start) begin
            r_cnt    <= '0;
            r_md_div <= w_md_div;
            r_neg_p  <= w_md_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= w_md_signed & a[WIDTH-1];
            r_b_zero <= (b == '0);
            r_bm     <= w_b_mag;
            r_wk_hi  <= '0;
            r_wk_lo  <= w_a_mag;
          end else begin
            r_result    <= w_result;
            r_zero      <= (w_result == '0);
            r_out_valid <= 1'b1;
            r_illegal   <= w_illegal;
          end
        end
        case (r_state)
          S_MUL: begin
            r_wk_hi <= w_mul_hi;
            r_wk_lo <= w_mul_lo;
            r_cnt   <= r_cnt + SHW'(1);
          end
          S_DIV: begin
            r_wk_hi <= w_div_rem;
            r_wk_lo <= w_div_quo;
            r_cnt   <= r_cnt + SHW'(1);
          end
          S_FIX: begin
            r_hi      <= w_fix_hi;
            r_lo      <= w_fix_lo;
            r_md_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ctrl      = r_ctrl;
  assign result    = r_result;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;
  assign illegal   = r_illegal;
  assign md_done   = r_md_done;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Directed bench for alu_exec_unit (WIDTH=32). A behavioural model computes
//   each cycle's expected outputs with plain integer arithmetic; one process
//   updates it on every rising edge and compares all outputs 1 time unit later.
//   The main sequence adds literal checks of hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    alu_op = '0;
  logic [5:0]    func = '0;
  logic [4:0]    shamt = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic [3:0]    ctrl;
  logic [W-1:0]  result;
  logic          zero, out_valid, illegal, md_done;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .EN_MULDIV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func(func), .shamt(shamt), .a(a), .b(b),
    .ctrl(ctrl), .result(result), .zero(zero), .out_valid(out_valid),
    .illegal(illegal), .md_done(md_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ov_cnt  = 0;
  int md_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_init = 1'b0;
  logic [W-1:0] m_result, m_hi, m_lo, p_hi, p_lo;
  logic [3:0]   m_ctrl;
  logic         m_zero, m_ov, m_ill, m_done, m_ready;
  int           m_rem = 0;   // edges left until HI/LO are written

  task automatic model_accept();
    logic [3:0]   c;
    logic [W-1:0] r;
    bit           il, md, sg, dv;
    int           sa, sb;
    longint       sp;
    logic [63:0]  up;
    c = 4'b0010; r = a + b; il = 0; md = 0; sg = 0; dv = 0;
    case (alu_op)
      2'b01: begin c = 4'b0110; r = a - b; end
      2'b11: begin c = 4'b0000; r = a & b; end
      2'b10: begin
        case (func)
          6'h20, 6'h21: ;
          6'h22, 6'h23: begin c = 4'b0110; r = a - b; end
          6'h24: begin c = 4'b0000; r = a & b; end
          6'h25: begin c = 4'b0001; r = a | b; end
          6'h26: begin c = 4'b0011; r = a ^ b; end
          6'h27: begin c = 4'b1100; r = ~(a | b); end
          6'h2a: begin c = 4'b0111; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'h2b: begin c = 4'b1000; r = (a < b) ? 32'd1 : 32'd0; end
          6'h00: begin c = 4'b1001; r = b << shamt; end
          6'h02: begin c = 4'b1010; r = b >> shamt; end
          6'h03: begin c = 4'b1011; r = $signed(b) >>> shamt; end
          6'h10: begin c = 4'b1101; r = m_hi; end
          6'h12: begin c = 4'b1110; r = m_lo; end
          6'h18: begin md = 1; sg = 1; end
          6'h19: begin md = 1; end
          6'h1a: begin md = 1; sg = 1; dv = 1; end
          6'h1b: begin md = 1; dv = 1; end
          default: il = 1;
        endcase
      end
      default: ;
    endcase
    m_ctrl = md ? 4'b1111 : c;
    if (md) begin
      m_rem = W;
      sa = $signed(a);
      sb = $signed(b);
      if (!dv) begin
        if (sg) begin sp = longint'(sa) * longint'(sb); {p_hi, p_lo} = sp; end
        else    begin up = {32'd0, a} * {32'd0, b};     {p_hi, p_lo} = up; end
      end else if (b == 0) begin
        p_lo = '1; p_hi = a;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        p_lo = 32'h8000_0000; p_hi = 0;
      end else if (sg) begin
        p_lo = sa / sb; p_hi = sa % sb;
      end else begin
        p_lo = a / b; p_hi = a % b;
      end
    end else begin
      m_result = r;
      m_zero   = (r == 0);
      m_ov     = 1;
      m_ill    = il;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_init = 1; m_result = 0; m_zero = 1; m_ctrl = 4'b0010;
      m_ov = 0; m_ill = 0; m_done = 0; m_hi = 0; m_lo = 0; m_rem = 0;
    end else begin
      m_ov = 0; m_ill = 0; m_done = 0;
      if (flush) m_rem = 0;
      else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
      end else if (in_valid) model_accept();
    end
    m_ready = (m_rem == 0);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_init) begin
        check("cyc_in_ready",  in_ready,  m_ready);
        check("cyc_out_valid", out_valid, m_ov);
        check("cyc_md_done",   md_done,   m_done);
        check("cyc_illegal",   illegal,   m_ill);
        check("cyc_result",    result,    m_result);
        check("cyc_zero",      zero,      m_zero);
        check("cyc_ctrl",      ctrl,      m_ctrl);
        if (out_valid === 1'b1) begin
          ov_cnt++;
          $display("[TB] %0t out ctrl=%b result=%h zero=%b illegal=%b", $time, ctrl, result, zero, illegal);
        end
        if (md_done === 1'b1) begin
          md_cnt++;
          $display("[TB] %0t md_done hi=%h lo=%h", $time, m_hi, m_lo);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present one op for one edge; returns at the next negedge with its result visible.
  task automatic op1(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                     input logic [W-1:0] aa, input logic [W-1:0] bb);
    alu_op = op; func = f; shamt = sh; a = aa; b = bb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Start a mult/div and wait (bounded) for md_done; optionally keep in_valid high while busy.
  task automatic md_run(input string name, input logic [5:0] f, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input bit hold_valid);
    int k;
    alu_op = 2'b10; func = f; a = aa; b = bb; in_valid = 1'b1;
    @(negedge clk);
    if (hold_valid) begin alu_op = 2'b00; a = 1; b = 1; end
    else in_valid = 1'b0;
    check({name, "_busy"}, in_ready, 1'b0);
    k = 0;
    while (md_done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    in_valid = 1'b0;
    check({name, "_latency"}, k, W);
    check({name, "_ready_at_done"}, in_ready, 1'b1);
  endtask

  initial begin
    int ov0, md0;
    // reset with garbage on the inputs
    rst_n = 1'b0; in_valid = 1'b1; a = 5;
    repeat (3) @(negedge clk);
    check("rst_result",    result,    32'h0);
    check("rst_zero",      zero,      1'b1);
    check("rst_ctrl",      ctrl,      4'b0010);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0;

    // legacy alu_op codes
    op1(2'b00, 6'h00, 0, 7, 3); check("add_res", result, 10); check("add_ctrl", ctrl, 4'b0010);
    op1(2'b01, 6'h00, 0, 7, 3); check("sub_res", result, 4);  check("sub_ctrl", ctrl, 4'b0110);
    op1(2'b11, 6'h00, 0, 7, 3); check("and_res", result, 3);  check("and_ctrl", ctrl, 4'b0000);
    op1(2'b01, 6'h00, 0, 7, 7); check("sub0_zero", zero, 1'b1); check("sub0_res", result, 0);

    // R-type
    op1(2'b10, 6'h2a, 0, 32'hFFFF_FFFF, 1); check("slt_res", result, 1); check("slt_ctrl", ctrl, 4'b0111);
    op1(2'b10, 6'h2b, 0, 32'hFFFF_FFFF, 1); check("sltu_res", result, 0);
    op1(2'b10, 6'h03, 4, 0, 32'h8000_0000); check("sra_res", result, 32'hF800_0000);
    op1(2'b10, 6'h27, 0, 0, 0); check("nor_res", result, 32'hFFFF_FFFF); check("nor_zero", zero, 1'b0);
    op1(2'b10, 6'h3f, 0, 10, 20);
    check("ill_flag", illegal, 1'b1); check("ill_res", result, 30); check("ill_ctrl", ctrl, 4'b0010);
    op1(2'b10, 6'h25, 0, 32'hF0, 32'h0F);
    op1(2'b10, 6'h26, 0, 32'hFF, 32'h0F);
    op1(2'b10, 6'h00, 31, 0, 32'h3);         check("sll_res", result, 32'h8000_0000);
    op1(2'b10, 6'h02, 4, 0, 32'h8000_0000);  check("srl_res", result, 32'h0800_0000);
    op1(2'b10, 6'h23, 0, 5, 9);

    // multiply
    md_run("mult", 6'h18, 32'hFFFF_FFFD, 5, 1'b0);
    check("mdl_mult_lo", m_lo, 32'hFFFF_FFF1);
    op1(2'b10, 6'h10, 0, 0, 0); check("mult_hi", result, 32'hFFFF_FFFF);
    op1(2'b10, 6'h12, 0, 0, 0); check("mult_lo", result, 32'hFFFF_FFF1);
    md_run("multu", 6'h19, 32'hFFFF_FFFF, 2, 1'b0);
    op1(2'b10, 6'h10, 0, 0, 0); check("multu_hi", result, 1);
    op1(2'b10, 6'h12, 0, 0, 0); check("multu_lo", result, 32'hFFFF_FFFE);

    // divide (the signed one with in_valid held high while busy)
    md_run("div", 6'h1a, 32'hFFFF_FFF9, 2, 1'b1);
    check("mdl_div_hi", m_hi, 32'hFFFF_FFFF);
    op1(2'b10, 6'h12, 0, 0, 0); check("div_lo", result, 32'hFFFF_FFFD);
    op1(2'b10, 6'h10, 0, 0, 0); check("div_hi", result, 32'hFFFF_FFFF);
    md_run("divu0", 6'h1b, 9, 0, 1'b0);
    op1(2'b10, 6'h12, 0, 0, 0); check("divu0_lo", result, 32'hFFFF_FFFF);
    op1(2'b10, 6'h10, 0, 0, 0); check("divu0_hi", result, 9);

    // flush on cycle 10 of a divide, with an add offered in the flush cycle
    alu_op = 2'b10; func = 6'h1a; a = 100; b = 7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    md0 = md_cnt;
    flush = 1'b1; alu_op = 2'b00; a = 1; b = 2; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_ready", in_ready, 1'b1);
    check("flush_no_out", out_valid, 1'b0);
    repeat (40) @(negedge clk);
    check("flush_no_md_done", md_cnt, md0);
    op1(2'b10, 6'h10, 0, 0, 0); check("flush_hi_kept", result, 9);
    op1(2'b10, 6'h12, 0, 0, 0); check("flush_lo_kept", result, 32'hFFFF_FFFF);

    // signed overflow case of divide
    md_run("divmin", 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    op1(2'b10, 6'h12, 0, 0, 0); check("divmin_lo", result, 32'h8000_0000);
    op1(2'b10, 6'h10, 0, 0, 0); check("divmin_hi", result, 0);

    // eight back-to-back adds
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) begin
      alu_op = 2'b00; a = i; b = 100; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_count", ov_cnt - ov0, 8);
    check("b2b_last", result, 107);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
